tick_gen_prog: RTL

- Multi-channel programmable clock-enable generator. Successor to the fixed divide-by-4 pixel-tick generator.
- Each channel produces a one-cycle tick every DIV system-clock cycles. DIV is programmable at runtime per channel.
- Each channel has its own enable, a free-running or one-shot mode, and a shared synchronous restart.
- Sits beside the VGA timing logic. Feeds pixel, frame and game-logic clock enables (e.g. 25 MHz pixel tick, ball/paddle update ticks) from the single 100 MHz clk.

---
 rtl/tick_gen_prog.sv | 107 ++++++++++
 1 files changed

// File: rtl/tick_gen_prog.sv
// Multi-channel programmable clock-enable generator: one tick every DIV clk cycles per channel,
// with per-channel enable, periodic/one-shot mode and a shared synchronous restart.

module tick_gen_ch #(
  parameter int CNT_W   = 16,
  parameter int DIV_RST = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  input  logic             wr_oneshot,
  output logic             tick,
  output logic             done
);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_RST);

  logic [CNT_W-1:0] q, div_act, div_shd, de, div_nxt;
  logic             mode_act, mode_shd, mode_nxt;
  logic             terminal, idle, load;

  // A divisor of zero runs exactly like a divisor of one.
  assign de       = (div_act == '0) ? ONE : div_act;
  assign terminal = (q == de - ONE);
  assign tick     = en & ~done & terminal;

  // Active divisor/mode only change between periods, so a period in flight
  // always finishes at the old rate. A write on the load edge is bypassed in.
  assign idle     = ~en | sync_clr | done;
  assign load     = idle | terminal;
  assign div_nxt  = wr ? wr_div     : div_shd;
  assign mode_nxt = wr ? wr_oneshot : mode_shd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q        <= '0;
      div_act  <= DIV_INIT;
      div_shd  <= DIV_INIT;
      mode_act <= 1'b0;
      mode_shd <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (wr) begin
        div_shd  <= wr_div;
        mode_shd <= wr_oneshot;
      end
      if (load) begin
        div_act  <= div_nxt;
        mode_act <= mode_nxt;
      end
      if (sync_clr || !en) begin
        q    <= '0;
        done <= 1'b0;
      end else if (done) begin
        q <= q;
      end else if (terminal) begin
        q <= '0;
        if (mode_act) done <= 1'b1;
      end else begin
        q <= q + ONE;
      end
    end
  end
endmodule

module tick_gen_prog #(
  parameter int CH_N    = 2,
  parameter int CNT_W   = 16,
  parameter int DIV_RST = 4,
  parameter int CH_W    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CH_N-1:0]  en,
  input  logic             sync_clr,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             cfg_oneshot,
  output logic [CH_N-1:0]  tick,
  output logic [CH_N-1:0]  done
);
  logic [CH_N-1:0] wr;

  // Writes to a channel index beyond CH_N match no decode and are dropped.
  for (genvar i = 0; i < CH_N; i++) begin : g_ch
    assign wr[i] = cfg_we & (cfg_ch == CH_W'(i));

    tick_gen_ch #(
      .CNT_W   (CNT_W),
      .DIV_RST (DIV_RST)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .en         (en[i]),
      .sync_clr   (sync_clr),
      .wr         (wr[i]),
      .wr_div     (cfg_div),
      .wr_oneshot (cfg_oneshot),
      .tick       (tick[i]),
      .done       (done[i])
    );
  end
endmodule
